rtcsync: RTL and testbench

PPS discipline controller and bus arbiter in front of `rtcclock`. It shares the rtcclock's single Wishbone slave port between the host and an internal sequencer. On each external pulse-per-second, the sequencer hacks the clock, reads back the hack phase and current `ckspeed`, and writes a corrected `ckspeed` to steer the RTC onto the PPS.

---
 rtl/rtcsync.sv | 164 ++++++++++++++++
 tb/tb_rtcsync.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rtcsync.sv
// rtcsync: PPS discipline sequencer and Wishbone arbiter in front of rtcclock.
// Ports: host wb (i_wb_*, o_wb_*), rtc port (o_rtc_*, i_rtc_data), i_pps, i_sync_en, o_busy/o_locked/o_err.
module rtcsync #(
  parameter int unsigned SHIFT       = 8,
  parameter logic [31:0] LOCK_THRESH = 32'h0010_0000,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_rtc_cyc,
  output logic        o_rtc_stb,
  output logic        o_rtc_we,
  output logic [2:0]  o_rtc_addr,
  output logic [31:0] o_rtc_data,
  input  logic [31:0] i_rtc_data,
  output logic        o_rtc_hack,
  input  logic        i_pps,
  input  logic        i_sync_en,
  output logic        o_busy,
  output logic        o_locked,
  output logic [31:0] o_err
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] GMAX = GW'(LOCK_COUNT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HACK  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RDTM  = 3'd3;
  localparam logic [2:0] S_RDCNT = 3'd4;
  localparam logic [2:0] S_RDSPD = 3'd5;
  localparam logic [2:0] S_CALC  = 3'd6;
  localparam logic [2:0] S_WR    = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [7:0]    sub_q;
  logic [23:0]   frac_q;
  logic [31:0]   spd_q;
  logic [31:0]   err_q;
  logic          ack_q;

  logic               idle;
  logic               host_ok;
  logic signed [32:0] err_x;
  logic signed [32:0] thr_x;
  logic               in_thr;
  logic [31:0]        adj;
  logic [31:0]        wr_val;

  logic        seq_cyc;
  logic        seq_we;
  logic [2:0]  seq_addr;
  logic [31:0] seq_data;

  assign idle    = (state_q == S_IDLE);
  // Host passthrough is gated by reset so every output is quiet while held.
  assign host_ok = idle && i_reset_n;

  // Sign-extended compare avoids the |0x8000_0000| overflow case.
  assign err_x  = {err_q[31], err_q};
  assign thr_x  = {1'b0, LOCK_THRESH};
  assign in_thr = (err_x <= thr_x) && (err_x >= -thr_x);
  assign adj    = $signed(err_q) >>> SHIFT;
  assign wr_val = spd_q - adj;

  always_comb begin
    seq_cyc  = 1'b0;
    seq_we   = 1'b0;
    seq_addr = 3'd0;
    seq_data = 32'd0;
    unique case (state_q)
      S_RDTM: begin
        seq_cyc  = 1'b1;
        seq_addr = 3'd5;
      end
      S_RDCNT: begin
        seq_cyc  = 1'b1;
        seq_addr = 3'd6;
      end
      S_RDSPD: begin
        seq_cyc  = 1'b1;
        seq_addr = 3'd4;
      end
      S_WR: begin
        seq_cyc  = in_thr;
        seq_we   = in_thr;
        seq_addr = 3'd4;
        seq_data = wr_val;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      S_IDLE: begin
        if (!i_sync_en) good_d = '0;
        else if (i_pps) state_d = S_HACK;
      end
      S_HACK:  state_d = S_WAIT;
      S_WAIT:  state_d = S_RDTM;
      S_RDTM:  state_d = S_RDCNT;
      S_RDCNT: state_d = S_RDSPD;
      S_RDSPD: state_d = S_CALC;
      S_CALC:  state_d = S_WR;
      S_WR: begin
        state_d = S_IDLE;
        if (!in_thr) good_d = '0;
        else if (good_q != GMAX) good_d = good_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      good_q  <= '0;
      sub_q   <= '0;
      frac_q  <= '0;
      spd_q   <= '0;
      err_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      ack_q   <= i_wb_cyc && i_wb_stb && idle;
      if (state_q == S_RDCNT) sub_q <= i_rtc_data[7:0];
      if (state_q == S_RDSPD) frac_q <= i_rtc_data[31:8];
      if (state_q == S_CALC) begin
        spd_q <= i_rtc_data;
        err_q <= {sub_q, frac_q};
      end
    end
  end

  assign o_wb_stall = !idle;
  assign o_busy     = !idle;
  assign o_wb_ack   = ack_q;
  assign o_wb_data  = ack_q ? i_rtc_data : 32'd0;
  assign o_rtc_hack = (state_q == S_HACK);
  assign o_err      = err_q;
  // Combinational so lock rises/falls in the WR cycle itself.
  assign o_locked   = (good_d == GMAX);

  assign o_rtc_cyc  = host_ok ? i_wb_cyc  : seq_cyc;
  assign o_rtc_stb  = host_ok ? i_wb_stb  : seq_cyc;
  assign o_rtc_we   = host_ok ? i_wb_we   : seq_we;
  assign o_rtc_addr = host_ok ? i_wb_addr : seq_addr;
  assign o_rtc_data = host_ok ? i_wb_data : seq_data;

endmodule

// File: tb/tb_rtcsync.sv
// tb_rtcsync: directed bench for rtcsync with a small rtcclock read model.
// Ports: drives all rtcsync inputs, checks outputs at #1 after each edge.
module tb_rtcsync;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic        i_wb_we = 1'b0;
  logic [2:0]  i_wb_addr = 3'd0;
  logic [31:0] i_wb_data = 32'd0;
  logic        o_wb_stall;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;
  logic        o_rtc_cyc;
  logic        o_rtc_stb;
  logic        o_rtc_we;
  logic [2:0]  o_rtc_addr;
  logic [31:0] o_rtc_data;
  logic [31:0] i_rtc_data;
  logic        o_rtc_hack;
  logic        i_pps = 1'b0;
  logic        i_sync_en = 1'b0;
  logic        o_busy;
  logic        o_locked;
  logic [31:0] o_err;

  logic [31:0] rtc_mem [8];
  int wr_cnt = 0;
  int snap = 0;
  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 i_clk = ~i_clk;

  rtcsync dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_wb_cyc   (i_wb_cyc),
    .i_wb_stb   (i_wb_stb),
    .i_wb_we    (i_wb_we),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .o_wb_stall (o_wb_stall),
    .o_wb_ack   (o_wb_ack),
    .o_wb_data  (o_wb_data),
    .o_rtc_cyc  (o_rtc_cyc),
    .o_rtc_stb  (o_rtc_stb),
    .o_rtc_we   (o_rtc_we),
    .o_rtc_addr (o_rtc_addr),
    .o_rtc_data (o_rtc_data),
    .i_rtc_data (i_rtc_data),
    .o_rtc_hack (o_rtc_hack),
    .i_pps      (i_pps),
    .i_sync_en  (i_sync_en),
    .o_busy     (o_busy),
    .o_locked   (o_locked),
    .o_err      (o_err)
  );

  always @(posedge i_clk) begin
    i_rtc_data <= rtc_mem[o_rtc_addr];
    if (o_rtc_cyc && o_rtc_stb && o_rtc_we) wr_cnt <= wr_cnt + 1;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic run_pps(input string n, input logic [31:0] e_err,
                         input logic e_wr, input logic [31:0] e_wd,
                         input logic e_l6, input logic e_l7);
    i_pps = 1'b1;
    tick();
    i_pps = 1'b0;
    chk({n, ":hack1"}, 32'(o_rtc_hack), 32'd1);
    chk({n, ":stall1"}, 32'(o_wb_stall), 32'd1);
    chk({n, ":busy1"}, 32'(o_busy), 32'd1);
    tick();
    chk({n, ":hack2"}, 32'(o_rtc_hack), 32'd0);
    chk({n, ":cyc2"}, 32'(o_rtc_cyc), 32'd0);
    tick();
    chk({n, ":addr3"}, 32'(o_rtc_addr), 32'd5);
    chk({n, ":cyc3"}, 32'(o_rtc_cyc), 32'd1);
    chk({n, ":we3"}, 32'(o_rtc_we), 32'd0);
    tick();
    chk({n, ":addr4"}, 32'(o_rtc_addr), 32'd6);
    tick();
    chk({n, ":addr5"}, 32'(o_rtc_addr), 32'd4);
    tick();
    chk({n, ":cyc6"}, 32'(o_rtc_cyc), 32'd0);
    chk({n, ":lock6"}, 32'(o_locked), 32'(e_l6));
    tick();
    chk({n, ":err7"}, o_err, e_err);
    chk({n, ":cyc7"}, 32'(o_rtc_cyc), 32'(e_wr));
    chk({n, ":lock7"}, 32'(o_locked), 32'(e_l7));
    if (e_wr) begin
      chk({n, ":we7"}, 32'(o_rtc_we), 32'd1);
      chk({n, ":addr7"}, 32'(o_rtc_addr), 32'd4);
      chk({n, ":wdata7"}, o_rtc_data, e_wd);
    end
    tick();
    chk({n, ":busy8"}, 32'(o_busy), 32'd0);
    chk({n, ":stall8"}, 32'(o_wb_stall), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rtc_mem[i] = 32'd0;
    tick();
    chk("rst:stall", 32'(o_wb_stall), 32'd0);
    chk("rst:ack", 32'(o_wb_ack), 32'd0);
    chk("rst:busy", 32'(o_busy), 32'd0);
    chk("rst:locked", 32'(o_locked), 32'd0);
    chk("rst:err", o_err, 32'd0);
    chk("rst:hack", 32'(o_rtc_hack), 32'd0);
    chk("rst:cyc", 32'(o_rtc_cyc), 32'd0);
    tick();
    i_reset_n = 1'b1;
    tick();
    i_sync_en = 1'b1;

    rtc_mem[5] = 32'h0000_0000;
    rtc_mem[6] = 32'h0010_0000;
    rtc_mem[4] = 32'h002A_F31E;
    run_pps("t1", 32'h0000_1000, 1'b1, 32'h002A_F30E, 1'b0, 1'b0);

    rtc_mem[5] = 32'h0000_00FF;
    rtc_mem[6] = 32'hFFFF_F000;
    run_pps("t2", 32'hFFFF_FFF0, 1'b1, 32'h002A_F31F, 1'b0, 1'b0);

    rtc_mem[5] = 32'h0000_0040;
    rtc_mem[6] = 32'h0010_0000;
    run_pps("t3", 32'h4000_1000, 1'b0, 32'd0, 1'b0, 1'b0);

    rtc_mem[5] = 32'h0000_0000;
    for (int k = 0; k < 4; k++)
      run_pps("lk", 32'h0000_1000, 1'b1, 32'h002A_F30E, 1'b0, k == 3);

    rtc_mem[5] = 32'h0000_0040;
    run_pps("drop", 32'h4000_1000, 1'b0, 32'd0, 1'b1, 1'b0);

    rtc_mem[0] = 32'hCAFE_0001;
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we = 1'b0;
    i_wb_addr = 3'd0;
    #1;
    chk("h:pass_cyc", 32'(o_rtc_cyc), 32'd1);
    chk("h:pass_addr", 32'(o_rtc_addr), 32'd0);
    chk("h:stall0", 32'(o_wb_stall), 32'd0);
    tick();
    chk("h:ack1", 32'(o_wb_ack), 32'd1);
    chk("h:data1", o_wb_data, 32'hCAFE_0001);
    i_pps = 1'b1;
    tick();
    i_pps = 1'b0;
    chk("h:ackT1", 32'(o_wb_ack), 32'd1);
    chk("h:dataT1", o_wb_data, 32'hCAFE_0001);
    chk("h:stallT1", 32'(o_wb_stall), 32'd1);
    chk("h:hackT1", 32'(o_rtc_hack), 32'd1);
    tick();
    chk("h:ackT2", 32'(o_wb_ack), 32'd0);
    for (int c = 3; c <= 7; c++) begin
      tick();
      chk("h:stallT3_7", 32'(o_wb_stall), 32'd1);
      chk("h:ackT3_7", 32'(o_wb_ack), 32'd0);
    end
    tick();
    chk("h:stallT8", 32'(o_wb_stall), 32'd0);
    chk("h:cycT8", 32'(o_rtc_cyc), 32'd1);
    chk("h:addrT8", 32'(o_rtc_addr), 32'd0);
    chk("h:ackT8", 32'(o_wb_ack), 32'd0);
    tick();
    chk("h:ackT9", 32'(o_wb_ack), 32'd1);
    chk("h:dataT9", o_wb_data, 32'hCAFE_0001);
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    tick();

    rtc_mem[5] = 32'h0000_0000;
    snap = wr_cnt;
    i_pps = 1'b1;
    tick();
    i_pps = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("r:addrT5", 32'(o_rtc_addr), 32'd4);
    i_reset_n = 1'b0;
    #1;
    chk("r:busy", 32'(o_busy), 32'd0);
    chk("r:stall", 32'(o_wb_stall), 32'd0);
    chk("r:hack", 32'(o_rtc_hack), 32'd0);
    chk("r:locked", 32'(o_locked), 32'd0);
    chk("r:err", o_err, 32'd0);
    chk("r:ack", 32'(o_wb_ack), 32'd0);
    chk("r:cyc", 32'(o_rtc_cyc), 32'd0);
    chk("r:we", 32'(o_rtc_we), 32'd0);
    chk("r:wdata", o_rtc_data, 32'd0);
    tick();
    tick();
    i_reset_n = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("r:nowrite", 32'(wr_cnt), 32'(snap));
    chk("r:idle", 32'(o_busy), 32'd0);

    i_sync_en = 1'b0;
    i_pps = 1'b1;
    tick();
    i_pps = 1'b0;
    chk("s:nohack", 32'(o_rtc_hack), 32'd0);
    chk("s:nobusy", 32'(o_busy), 32'd0);
    tick();
    chk("s:nobusy2", 32'(o_busy), 32'd0);
    chk("s:nowrite", 32'(wr_cnt), 32'(snap));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
